fft_input_sched: RTL
====================

// Module: fft_input_sched
// PURPOSE
//  Job controller between the 4-lane input reader and the downstream 4-lane datapath.
//  On a go pulse it raises the reader start level and captures each 4-word beat into a
//  small FIFO. It drops start once the reader reports done, then drains the FIFO
//  under ready/valid back-pressure. Each beat is tagged with frame index and
//  start/end-of-frame markers. Short jobs and dropped beats are flagged.
// PARAMETERS
//  WORDSIZE      16   bits per sample word
//  NUMSAMPLES    32   samples per frame; BPF = NUMSAMPLES/4 = 8 beats per frame
//  TOTALSAMPLES  96   samples per job; TOTAL_BEATS = TOTALSAMPLES/4 = 24; must be a multiple of NUMSAMPLES
//  FIFO_DEPTH    4    beat FIFO depth; power of 2, >= 2
// PORTS
//  clk        in   1            clock, all logic on rising edge
//  rst_n      in   1            synchronous active-low reset
//  go         in   1            job start pulse; ignored unless in IDLE
//  busy       out  1            high in any state other than IDLE
//  rd_s       out  1            reader start level
//  rd_valid   in   1            reader beat strobe
//  rd_done    in   1            reader finished
//  rd_data0-3 in   WORDSIZE     reader lanes 0..3
//  out_valid  out  1            FIFO non-empty
//  out_ready  in   1            downstream accepts head beat
//  out_data   out  4*WORDSIZE   {lane3,lane2,lane1,lane0} of head beat
//  out_sof    out  1            head beat is beat 0 of its frame
//  out_eof    out  1            head beat is beat BPF-1 of its frame
//  out_frame  out  clog2(TOTALSAMPLES/NUMSAMPLES)  frame index of head beat
//  job_done   out  1            one-cycle pulse at job end
//  overflow   out  1            sticky: a beat was dropped
//  short_err  out  1            sticky: beat count was not TOTAL_BEATS
// BEHAVIOUR
//  Reset (rst_n=0 at edge):
//   - state=IDLE; FIFO flushed; counters=0.
//   - All outputs 0: rd_s, busy, out_valid, out_sof, out_eof, out_frame, job_done, overflow, short_err.
//   - Reset mid-job aborts the job and emits no job_done.
//  FSM:
//   - IDLE --go--> LOAD. Same edge: clear in_cnt, out_cnt, overflow, short_err.
//   - LOAD: rd_s=1. Every rd_valid beat increments in_cnt and pushes to the FIFO if space.
//     On rd_done -> RELEASE.
//   - RELEASE: rd_s=0 for exactly 1 cycle.
//     short_err <= (in_cnt != TOTAL_BEATS); this count includes any beat accepted together with rd_done.
//     -> DRAIN.
//   - DRAIN: rd_valid is ignored and not counted. When the FIFO is empty -> FINISH.
//   - FINISH: job_done=1 for 1 cycle -> IDLE.
//  rd_valid and rd_done in the same LOAD cycle: the beat is captured, then the FSM moves to RELEASE.
//  FIFO / handshake:
//   - Push at edge N makes out_valid=1 from cycle N+1 (1-cycle latency).
//   - Pop when out_valid && out_ready. out_data, sof, eof and frame hold stable while valid && !ready.
//   - Push while full with no pop in the same cycle: beat dropped, overflow<=1.
//   - Push while full with a pop in the same cycle: accepted, no overflow.
//   - Pointers wrap modulo FIFO_DEPTH; a separate count distinguishes full from empty.
//  Tags derive from out_cnt (popped beats this job):
//   - out_sof = (out_cnt % BPF == 0)
//   - out_eof = (out_cnt % BPF == BPF-1)
//   - out_frame = out_cnt / BPF
//   - out_cnt saturates at TOTAL_BEATS-1 for tagging.
//  go while busy is ignored. Sticky flags hold until the next accepted go or reset.
// TESTING
//  1. go, 24 rd_valid beats with out_ready=1, then rd_done:
//     24 beats out; sof at beats 0/8/16; eof at 7/15/23; frame 0,1,2;
//     one job_done; short_err=0; overflow=0.
//  2. out_ready=0 and 5 beats pushed (DEPTH 4): overflow=1; 4 beats held stable;
//     after release, out_frame=0 and sof on the first beat only.
//  3. Full FIFO, rd_valid and out_ready both high in the same cycle:
//     beat accepted, overflow stays 0, count stays 4.
//  4. rd_done after 20 beats: short_err=1 in the cycle after RELEASE;
//     20 beats drain; job_done pulses once.
//  5. rst_n=0 for 1 cycle mid-LOAD with 3 beats queued:
//     next cycle rd_s=0, out_valid=0, busy=0, no job_done; a new go runs test 1 cleanly.
//  6. go pulsed during DRAIN: ignored; rd_s stays 0; exactly one job_done.

Source files
------------

// File: rtl/fft_input_sched.sv
// Job controller: drives the 4-lane reader, buffers beats in a small FIFO and drains them tagged with SOF/EOF/frame.
// Beats appear on out_* one cycle after capture; out_ready low holds the head beat, reader beats are dropped when full.
module fft_input_sched #(
  parameter  int WORDSIZE     = 16,
  parameter  int NUMSAMPLES   = 32,
  parameter  int TOTALSAMPLES = 96,
  parameter  int FIFO_DEPTH   = 4,
  localparam int NFRAMES      = TOTALSAMPLES / NUMSAMPLES,
  localparam int FRAME_W      = (NFRAMES > 1) ? $clog2(NFRAMES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  output logic                  busy,
  output logic                  rd_s,
  input  logic                  rd_valid,
  input  logic                  rd_done,
  input  logic [WORDSIZE-1:0]   rd_data0,
  input  logic [WORDSIZE-1:0]   rd_data1,
  input  logic [WORDSIZE-1:0]   rd_data2,
  input  logic [WORDSIZE-1:0]   rd_data3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*WORDSIZE-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic [FRAME_W-1:0]    out_frame,
  output logic                  job_done,
  output logic                  overflow,
  output logic                  short_err
);

  localparam int BPF         = NUMSAMPLES / 4;
  localparam int TOTAL_BEATS = TOTALSAMPLES / 4;
  localparam int BEAT_W      = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam int IN_W        = $clog2(TOTAL_BEATS + 1) + 1;

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BPF - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NFRAMES - 1);
  localparam logic [IN_W-1:0]    IN_TARGET  = IN_W'(TOTAL_BEATS);
  localparam logic [IN_W-1:0]    IN_MAX     = '1;
  localparam logic [CNT_W-1:0]   DEPTH_C    = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  logic [2:0]            state;
  logic [4*WORDSIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [IN_W-1:0]       in_cnt;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [FRAME_W-1:0]    frame_cnt;

  logic go_ok;
  logic push_req;
  logic push;
  logic pop;
  logic full;
  logic tag_last;

  assign go_ok     = go && (state == S_IDLE);
  assign out_valid = (count != '0);
  assign full      = (count == DEPTH_C);
  assign pop       = out_valid && out_ready;
  assign push_req  = (state == S_LOAD) && rd_valid;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);
  assign tag_last  = (beat_cnt == LAST_BEAT) && (frame_cnt == LAST_FRAME);

  assign busy      = (state != S_IDLE);
  assign rd_s      = (state == S_LOAD);
  assign job_done  = (state == S_FINISH);
  assign out_data  = mem[rd_ptr];
  assign out_sof   = out_valid && (beat_cnt == '0);
  assign out_eof   = out_valid && (beat_cnt == LAST_BEAT);
  assign out_frame = frame_cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rd_data3, rd_data2, rd_data1, rd_data0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_cnt    <= '0;
      beat_cnt  <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
      short_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE:    if (go) state <= S_LOAD;
        S_LOAD:    if (rd_done) state <= S_RELEASE;
        S_RELEASE: state <= S_DRAIN;
        S_DRAIN:   if (!out_valid) state <= S_FINISH;
        S_FINISH:  state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);

      if (go_ok)                              in_cnt <= '0;
      else if (push_req && (in_cnt != IN_MAX)) in_cnt <= in_cnt + IN_W'(1);

      if (go_ok)                            overflow <= 1'b0;
      else if (push_req && full && !pop)    overflow <= 1'b1;

      if (go_ok)                      short_err <= 1'b0;
      else if (state == S_RELEASE)    short_err <= (in_cnt != IN_TARGET);

      // Tags stop advancing on the final beat of the job.
      if (go_ok) begin
        beat_cnt  <= '0;
        frame_cnt <= '0;
      end else if (pop && !tag_last) begin
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt  <= '0;
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end else begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end
    end
  end

endmodule
